decode_rename_uop_queue: RTL and testbench

//  Parametrised multiported uop queue between the decoder output and the rename stage. Lets

---
 rtl/decode_rename_uop_queue.sv | 144 ++++++++++++++
 tb/tb_decode_rename_uop_queue.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_rename_uop_queue.sv
// decode_rename_uop_queue: multiported in-order uop buffer between decode and rename.
// Selectively squashes on mispredict and clears resolved kill-mask bits in place.
module decode_rename_uop_queue #(
    parameter int WR_PORTS = 4,
    parameter int RD_PORTS = 2,
    parameter int DEPTH    = 8,
    parameter int UOP_W    = 128,
    parameter int SPEC_W   = 8,
    parameter int KM_LSB   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          Flush,
    input  logic [WR_PORTS*UOP_W-1:0]     Enq_Uops,
    input  logic [WR_PORTS-1:0]           Enq_Valid,
    output logic [$clog2(WR_PORTS):0]     Enq_Cnt,
    output logic [RD_PORTS*UOP_W-1:0]     Deq_Uops,
    output logic [RD_PORTS-1:0]           Deq_Valid,
    input  logic [$clog2(RD_PORTS):0]     Deq_Cnt,
    input  logic                          Br_Valid,
    input  logic                          Br_Mispred,
    input  logic [SPEC_W-1:0]             Br_Spectag,
    output logic [$clog2(DEPTH):0]        Free_Cnt,
    output logic                          Empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = $clog2(WR_PORTS) + 1;

    logic [UOP_W-1:0] mem [DEPTH];
    logic [PW-1:0]    head, tail, occ, avail;
    logic [PW-1:0]    enq_n, deq_n, kill_tail, scan_ptr;
    logic [PW-1:0]    rd_ptr [RD_PORTS];
    logic [PW-1:0]    wr_ptr [WR_PORTS];
    logic [UOP_W-1:0] wr_uop [WR_PORTS];
    logic [EW-1:0]    run_len;
    logic             lead, hit, misp, resolve;

    assign misp     = Br_Valid & Br_Mispred;
    assign resolve  = Br_Valid & ~Br_Mispred;
    assign occ      = tail - head;
    assign Free_Cnt = PW'(DEPTH) - occ;
    assign Empty    = (occ == '0);
    assign avail    = (occ < PW'(RD_PORTS)) ? occ : PW'(RD_PORTS);
    assign enq_n    = PW'(Enq_Cnt);

    // Only the unbroken run of valid slots from slot 0 is eligible.
    always_comb begin
        lead    = 1'b1;
        run_len = '0;
        for (int i = 0; i < WR_PORTS; i++) begin
            lead    = lead & Enq_Valid[i];
            run_len = run_len + EW'(lead);
        end
    end

    always_comb begin
        if (!rst || Flush || misp)
            Enq_Cnt = '0;
        else if (PW'(run_len) > Free_Cnt)
            Enq_Cnt = EW'(Free_Cnt);
        else
            Enq_Cnt = run_len;
    end

    always_comb begin
        deq_n = PW'(Deq_Cnt);
        if (deq_n > avail)
            deq_n = avail;
        if (Flush || misp)
            deq_n = '0;
    end

    always_comb begin
        Deq_Uops  = '0;
        Deq_Valid = '0;
        for (int j = 0; j < RD_PORTS; j++) begin
            rd_ptr[j] = head + PW'(j);
            Deq_Uops[j*UOP_W +: UOP_W] = mem[rd_ptr[j][AW-1:0]];
            if (resolve)
                Deq_Uops[j*UOP_W+KM_LSB +: SPEC_W] =
                    mem[rd_ptr[j][AW-1:0]][KM_LSB +: SPEC_W] & ~Br_Spectag;
            Deq_Valid[j] = !misp && (PW'(j) < occ);
        end
    end

    always_comb begin
        for (int i = 0; i < WR_PORTS; i++) begin
            wr_ptr[i] = tail + PW'(i);
            wr_uop[i] = Enq_Uops[i*UOP_W +: UOP_W];
            if (resolve)
                wr_uop[i][KM_LSB +: SPEC_W] =
                    Enq_Uops[i*UOP_W+KM_LSB +: SPEC_W] & ~Br_Spectag;
        end
    end

    // Oldest entry carrying the mispredicted tag becomes the new tail.
    always_comb begin
        kill_tail = tail;
        hit       = 1'b0;
        scan_ptr  = head;
        for (int k = 0; k < DEPTH; k++) begin
            scan_ptr = head + PW'(k);
            if (!hit && (PW'(k) < occ) &&
                |(mem[scan_ptr[AW-1:0]][KM_LSB +: SPEC_W] & Br_Spectag)) begin
                hit       = 1'b1;
                kill_tail = scan_ptr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
        end else if (Flush) begin
            head <= '0;
            tail <= '0;
        end else if (misp) begin
            tail <= kill_tail;
        end else begin
            head <= head + deq_n;
            tail <= tail + enq_n;
        end
    end

    always_ff @(posedge clk) begin
        if (resolve)
            for (int k = 0; k < DEPTH; k++)
                mem[k][KM_LSB +: SPEC_W] <= mem[k][KM_LSB +: SPEC_W] & ~Br_Spectag;
        for (int i = 0; i < WR_PORTS; i++)
            if (EW'(i) < Enq_Cnt)
                mem[wr_ptr[i][AW-1:0]] <= wr_uop[i];
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst && !Flush && !misp)
            assert (PW'(Deq_Cnt) <= avail)
            else $error("Deq_Cnt %0d exceeds live uops %0d", Deq_Cnt, avail);
    end
`endif

endmodule

// File: tb/tb_decode_rename_uop_queue.sv
// tb_decode_rename_uop_queue: random and directed checks against a queue-based model.
// The model keeps uops in a SV queue, front = oldest.
module tb_decode_rename_uop_queue;
    localparam int WR = 4, RD = 2, DEPTH = 8, UW = 128, SW = 8, KM = 0;

    logic            clk = 1'b0;
    logic            rst, Flush;
    logic [WR*UW-1:0] Enq_Uops;
    logic [WR-1:0]   Enq_Valid;
    logic [2:0]      Enq_Cnt;
    logic [RD*UW-1:0] Deq_Uops;
    logic [RD-1:0]   Deq_Valid;
    logic [1:0]      Deq_Cnt;
    logic            Br_Valid, Br_Mispred;
    logic [SW-1:0]   Br_Spectag;
    logic [3:0]      Free_Cnt;
    logic            Empty;

    decode_rename_uop_queue #(
        .WR_PORTS(WR), .RD_PORTS(RD), .DEPTH(DEPTH),
        .UOP_W(UW), .SPEC_W(SW), .KM_LSB(KM)
    ) dut (
        .clk(clk), .rst(rst), .Flush(Flush),
        .Enq_Uops(Enq_Uops), .Enq_Valid(Enq_Valid), .Enq_Cnt(Enq_Cnt),
        .Deq_Uops(Deq_Uops), .Deq_Valid(Deq_Valid), .Deq_Cnt(Deq_Cnt),
        .Br_Valid(Br_Valid), .Br_Mispred(Br_Mispred), .Br_Spectag(Br_Spectag),
        .Free_Cnt(Free_Cnt), .Empty(Empty)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    logic [UW-1:0] q[$];

    task automatic check(input string tag, input logic [UW-1:0] got,
                         input logic [UW-1:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [UW-1:0] mk(input logic [SW-1:0] m);
        logic [UW-1:0] u;
        u = {$urandom, $urandom, $urandom, $urandom};
        u[KM +: SW] = m;
        return u;
    endfunction

    function automatic int lead_ones(input logic [WR-1:0] v);
        int n = 0;
        for (int i = 0; i < WR; i++) begin
            if (!v[i]) break;
            n++;
        end
        return n;
    endfunction

    task automatic idle();
        Flush = 0; Br_Valid = 0; Br_Mispred = 0; Br_Spectag = '0;
        Enq_Valid = '0; Deq_Cnt = '0;
    endtask

    task automatic load(input int i, input logic [SW-1:0] m);
        Enq_Uops[i*UW +: UW] = mk(m);
    endtask

    // Check all outputs against the model, clock once, then update the model.
    task automatic run_cycle();
        int n, ecnt, free, avail, dq, k;
        logic misp, corr, v;
        logic [UW-1:0] u;
        #1;
        misp = Br_Valid && Br_Mispred;
        corr = Br_Valid && !Br_Mispred;
        free = DEPTH - q.size();
        n = lead_ones(Enq_Valid);
        ecnt = (Flush || misp) ? 0 : (n < free ? n : free);
        check("free_cnt", UW'(Free_Cnt), UW'(free));
        check("empty", UW'(Empty), UW'(q.size() == 0));
        check("enq_cnt", UW'(Enq_Cnt), UW'(ecnt));
        for (int j = 0; j < RD; j++) begin
            v = (j < q.size()) && !misp;
            check("deq_valid", UW'(Deq_Valid[j]), UW'(v));
            if (v) begin
                u = q[j];
                if (corr) u[KM +: SW] = u[KM +: SW] & ~Br_Spectag;
                check("deq_uop", Deq_Uops[j*UW +: UW], u);
            end
        end
        @(posedge clk);
        if (Flush) begin
            q.delete();
        end else if (misp) begin
            k = q.size();
            for (int i = 0; i < q.size(); i++) begin
                u = q[i];
                if ((u[KM +: SW] & Br_Spectag) != 0) begin
                    k = i;
                    break;
                end
            end
            while (q.size() > k) void'(q.pop_back());
        end else begin
            if (corr)
                for (int i = 0; i < q.size(); i++) begin
                    u = q[i];
                    u[KM +: SW] = u[KM +: SW] & ~Br_Spectag;
                    q[i] = u;
                end
            avail = q.size() < RD ? q.size() : RD;
            dq = int'(Deq_Cnt) < avail ? int'(Deq_Cnt) : avail;
            repeat (dq) void'(q.pop_front());
            for (int i = 0; i < ecnt; i++) begin
                u = Enq_Uops[i*UW +: UW];
                if (corr) u[KM +: SW] = u[KM +: SW] & ~Br_Spectag;
                q.push_back(u);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int avail;
        rst = 0;
        Enq_Uops = '0;
        idle();
        repeat (2) @(negedge clk);
        rst = 1;
        run_cycle();

        // Reset asserted mid-burst with five uops held.
        for (int i = 0; i < WR; i++) load(i, 8'h00);
        Enq_Valid = 4'b1111; run_cycle();
        Enq_Valid = 4'b0001; run_cycle();
        check("pre_rst_free", UW'(Free_Cnt), UW'(3));
        Enq_Valid = 4'b1111;
        #2 rst = 0;
        #1;
        check("rst_empty", UW'(Empty), UW'(1));
        check("rst_free", UW'(Free_Cnt), UW'(8));
        check("rst_deq_valid", UW'(Deq_Valid), UW'(0));
        check("rst_enq_cnt", UW'(Enq_Cnt), UW'(0));
        q.delete();
        @(negedge clk);
        rst = 1;
        idle();

        // Gap in valid bits truncates the accepted run.
        for (int i = 0; i < WR; i++) load(i, 8'h00);
        Enq_Valid = 4'b1011;
        #1 check("gap_enq_cnt", UW'(Enq_Cnt), UW'(2));
        run_cycle();
        idle();
        #1 check("gap_deq_valid", UW'(Deq_Valid), UW'(2'b11));
        run_cycle();

        // Fill, drain two, then refill across the wrap with only two free.
        Flush = 1; run_cycle(); idle();
        for (int i = 0; i < WR; i++) load(i, 8'h00);
        Enq_Valid = 4'b1111; run_cycle();
        for (int i = 0; i < WR; i++) load(i, 8'h00);
        run_cycle();
        idle(); Deq_Cnt = 2; run_cycle();
        for (int i = 0; i < WR; i++) load(i, 8'h00);
        Enq_Valid = 4'b1111; Deq_Cnt = 2;
        #1 check("wrap_enq_cnt", UW'(Enq_Cnt), UW'(2));
        run_cycle();
        idle();
        #1 check("wrap_occ", UW'(Free_Cnt), UW'(2));
        run_cycle();

        // Selective squash: masks 00,00,01,01,03,01 with tag 01 keeps A,B.
        Flush = 1; run_cycle(); idle();
        load(0, 8'h00); load(1, 8'h00); load(2, 8'h01); load(3, 8'h01);
        Enq_Valid = 4'b1111; run_cycle();
        load(0, 8'h03); load(1, 8'h01);
        Enq_Valid = 4'b0011; run_cycle();
        Enq_Valid = 4'b1111; Br_Valid = 1; Br_Mispred = 1; Br_Spectag = 8'h01;
        #1 check("misp_enq_cnt", UW'(Enq_Cnt), UW'(0));
        run_cycle();
        idle();
        #1 check("misp_free", UW'(Free_Cnt), UW'(6));
        run_cycle();

        // Correct resolve clears bit 1 in stored, incoming and displayed uops.
        Flush = 1; run_cycle(); idle();
        load(0, 8'h03); load(1, 8'h03);
        Enq_Valid = 4'b0011; run_cycle();
        load(0, 8'h03); load(1, 8'h03);
        Enq_Valid = 4'b0011; Br_Valid = 1; Br_Spectag = 8'h02;
        #1 check("res_same_cycle", UW'(Deq_Uops[KM +: SW]), UW'(8'h01));
        run_cycle();
        idle(); Deq_Cnt = 2;
        #1 check("res_stored", UW'(Deq_Uops[UW+KM +: SW]), UW'(8'h01));
        run_cycle();
        #1 check("res_incoming", UW'(Deq_Uops[KM +: SW]), UW'(8'h01));
        run_cycle();
        idle();

        // Flush outranks mispredict and enqueue.
        for (int i = 0; i < WR; i++) load(i, 8'h01);
        Enq_Valid = 4'b1111; run_cycle();
        Flush = 1; Br_Valid = 1; Br_Mispred = 1; Br_Spectag = 8'h01;
        #1 check("flush_enq_cnt", UW'(Enq_Cnt), UW'(0));
        run_cycle();
        idle();
        #1 check("flush_empty", UW'(Empty), UW'(1));
        run_cycle();

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            Flush      = ($urandom_range(0, 39) == 0);
            Br_Valid   = ($urandom_range(0, 4) == 0);
            Br_Mispred = ($urandom_range(0, 2) == 0);
            Br_Spectag = SW'(1 << $urandom_range(0, 3));
            Enq_Valid  = WR'($urandom);
            for (int i = 0; i < WR; i++) load(i, SW'($urandom_range(0, 15)));
            avail = q.size() < RD ? q.size() : RD;
            Deq_Cnt = 2'($urandom_range(0, avail));
            run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
